// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hazard_pkg
// Brief    : Shared constants, shadow-tag types and helpers for the hazard
//            detection / forwarding controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Default register address width (32-entry MIPS register file)
  localparam int DEF_ADDR_W = 5;

  // Forwarding mux select encodings for the EX operand muxes
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  // Shadow tag for the instruction currently in EX
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] rs;
    logic [DEF_ADDR_W-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [DEF_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } ex_tag_t;

  // Shadow tag for MEM and WB: only the producer side is still of interest
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } late_tag_t;

  // Drop the source-operand fields when an EX tag moves on to MEM
  function automatic late_tag_t to_late(input ex_tag_t t);
    late_tag_t r;
    r.valid    = t.valid;
    r.dest     = t.dest;
    r.regwrite = t.regwrite;
    r.memread  = t.memread;
    return r;
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/reg_addr_match.sv
`default_nettype none
// ============================================================================
// Module   : reg_addr_match
// Brief    : Producer/consumer register address comparator. Hits when a live
//            register writer targets a nonzero register the consumer reads.
// Revision : 1.0 - initial release
// ============================================================================
module reg_addr_match #(
  parameter int ADDR_W = 5
) (
  input  logic              valid,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] dest,
  input  logic [ADDR_W-1:0] src,
  input  logic              src_used,
  output logic              hit
);

  // $0 is hard-wired to zero, so a write to it never produces a value to match
  assign hit = valid && regwrite && src_used && (dest != '0) && (dest == src);

endmodule : reg_addr_match
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Brief    : Hazard detection and forwarding controller for a 5-stage MIPS
//            pipeline. Tracks EX/MEM/WB register tags, drives the EX operand
//            forwarding selects, load-use stall, branch flush, ID regfile
//            bypass and a saturating load-use stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              id_byp_rs,
  output logic              id_byp_rt,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  ex_tag_t          r_ex;
  late_tag_t        r_mem;
  late_tag_t        r_wb;
  ex_tag_t          w_ex_next;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_lu_rs, w_lu_rt, w_load_use, w_flush;
  logic w_mem_a, w_wb_a, w_mem_b, w_wb_b;
  logic w_unused;

  // The WB load flag only matters while the load sits in MEM
  assign w_unused = &{1'b0, r_wb.memread};

  // Load in EX feeding the instruction in ID: data is not ready for a forward
  reg_addr_match #(.ADDR_W(ADDR_W)) u_lu_rs (
    .valid(r_ex.valid && r_ex.memread && id_valid), .regwrite(r_ex.regwrite),
    .dest(r_ex.dest), .src(id_rs), .src_used(id_uses_rs), .hit(w_lu_rs));
  reg_addr_match #(.ADDR_W(ADDR_W)) u_lu_rt (
    .valid(r_ex.valid && r_ex.memread && id_valid), .regwrite(r_ex.regwrite),
    .dest(r_ex.dest), .src(id_rt), .src_used(id_uses_rt), .hit(w_lu_rt));

  // MEM forward excludes loads: their data only exists once they reach WB
  reg_addr_match #(.ADDR_W(ADDR_W)) u_fwd_mem_a (
    .valid(r_mem.valid && !r_mem.memread), .regwrite(r_mem.regwrite),
    .dest(r_mem.dest), .src(r_ex.rs), .src_used(r_ex.uses_rs), .hit(w_mem_a));
  reg_addr_match #(.ADDR_W(ADDR_W)) u_fwd_mem_b (
    .valid(r_mem.valid && !r_mem.memread), .regwrite(r_mem.regwrite),
    .dest(r_mem.dest), .src(r_ex.rt), .src_used(r_ex.uses_rt), .hit(w_mem_b));
  reg_addr_match #(.ADDR_W(ADDR_W)) u_fwd_wb_a (
    .valid(r_wb.valid), .regwrite(r_wb.regwrite),
    .dest(r_wb.dest), .src(r_ex.rs), .src_used(r_ex.uses_rs), .hit(w_wb_a));
  reg_addr_match #(.ADDR_W(ADDR_W)) u_fwd_wb_b (
    .valid(r_wb.valid), .regwrite(r_wb.regwrite),
    .dest(r_wb.dest), .src(r_ex.rt), .src_used(r_ex.uses_rt), .hit(w_wb_b));

  // WB writes the regfile in the same cycle ID reads it
  reg_addr_match #(.ADDR_W(ADDR_W)) u_byp_rs (
    .valid(r_wb.valid && id_valid), .regwrite(r_wb.regwrite),
    .dest(r_wb.dest), .src(id_rs), .src_used(id_uses_rs), .hit(id_byp_rs));
  reg_addr_match #(.ADDR_W(ADDR_W)) u_byp_rt (
    .valid(r_wb.valid && id_valid), .regwrite(r_wb.regwrite),
    .dest(r_wb.dest), .src(id_rt), .src_used(id_uses_rt), .hit(id_byp_rt));

  assign w_load_use = w_lu_rs || w_lu_rt;
  assign w_flush    = ex_branch_taken;

  // Pipeline control: a taken branch wins over a load-use stall
  always_comb begin
    pc_write    = w_flush || !w_load_use;
    ifid_write  = w_flush || !w_load_use;
    ifid_flush  = w_flush;
    idex_bubble = w_flush || w_load_use;
  end

  // Operand forwarding selects: youngest producer (MEM) takes priority
  always_comb begin
    fwd_a_sel = w_mem_a ? FWD_MEM : (w_wb_a ? FWD_WB : FWD_REGFILE);
    fwd_b_sel = w_mem_b ? FWD_MEM : (w_wb_b ? FWD_WB : FWD_REGFILE);
  end

  // Next EX tag: the ID instruction, or an all-zero NOP when a bubble is injected
  always_comb begin
    w_ex_next          = '0;
    if (!idex_bubble) begin
      w_ex_next.valid    = id_valid;
      w_ex_next.rs       = id_rs;
      w_ex_next.rt       = id_rt;
      w_ex_next.uses_rs  = id_uses_rs;
      w_ex_next.uses_rt  = id_uses_rt;
      w_ex_next.dest     = id_dest;
      w_ex_next.regwrite = id_regwrite;
      w_ex_next.memread  = id_memread;
    end
  end

  // Shadow tag pipeline advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= to_late(r_ex);
      r_wb  <= r_mem;
    end
  end

  // Saturating count of real load-use stalls (flush cycles excluded)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_load_use && !w_flush && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule : hazard_fwd_ctrl
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Brief    : Self-checking bench for hazard_fwd_ctrl (CNT_W=2 so that the
//            stall counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

  localparam int AW = 5;
  localparam int CW = 2;

  // Expected output bundle: {pcw, ifw, ifl, bub, fa[1:0], fb[1:0], byp_rs, byp_rt}
  localparam logic [9:0] O_DEF   = 10'b1100000000;
  localparam logic [9:0] O_STALL = 10'b0001000000;
  localparam logic [9:0] O_FLUSH = 10'b1111000000;
  localparam logic [9:0] O_FA10  = 10'b1100100000;
  localparam logic [9:0] O_FA01  = 10'b1100010000;
  localparam logic [9:0] O_FAB10 = 10'b1100101000;
  localparam logic [9:0] O_BYPRS = 10'b1100000010;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic          id_regwrite = 1'b0, id_memread = 1'b0, ex_branch_taken = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, id_byp_rs, id_byp_rt;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_fwd_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .id_byp_rs(id_byp_rs), .id_byp_rt(id_byp_rt), .stall_count(stall_count));

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic          v;
    logic [AW-1:0] rs, rt, dest;
    logic          urs, urt, rw, mr, br;
    logic [9:0]    eo;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string nm, logic v, int rs, int rt, logic urs, logic urt,
                              int dest, logic rw, logic mr, logic br,
                              logic [9:0] eo, int cnt);
    vec_t t;
    t.nm = nm; t.v = v; t.rs = AW'(rs); t.rt = AW'(rt); t.urs = urs; t.urt = urt;
    t.dest = AW'(dest); t.rw = rw; t.mr = mr; t.br = br; t.eo = eo; t.cnt = CW'(cnt);
    return t;
  endfunction

  function automatic vec_t nop(string nm, logic br, logic [9:0] eo, int cnt);
    return mk(nm, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, br, eo, cnt);
  endfunction

  // Drive one ID-stage record and queue its expected outputs
  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_uses_rs = t.urs; id_uses_rt = t.urt;
    id_dest = t.dest; id_regwrite = t.rw; id_memread = t.mr; ex_branch_taken = t.br;
    sb.push_back(t);
  endtask

  // Pop the oldest expectation and compare against the DUT outputs now
  task automatic check_next();
    vec_t       e;
    logic [9:0] act;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e   = sb.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel,
             id_byp_rs, id_byp_rt};
      if (act !== e.eo || stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 e.nm, act, stall_count, e.eo, e.cnt);
      end
    end
  endtask

  // One pipeline cycle: drive after the edge, compare at the falling edge
  task automatic run(input vec_t t);
    @(posedge clk); #1;
    drive(t);
    @(negedge clk);
    check_next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;

    // ---- directed table: (nm, v, rs, rt, urs, urt, dest, rw, mr, br, outs, cnt)
    tbl.push_back(mk("alu_add3",      1, 1, 2, 1, 1, 3, 1, 0, 0, O_DEF,   0));
    tbl.push_back(mk("alu_sub_rd3",   1, 3, 5, 1, 1, 4, 1, 0, 0, O_DEF,   0));
    tbl.push_back(nop("alu_fwd_mem",  0, O_FA10, 0));
    tbl.push_back(nop("alu_drain",    0, O_DEF,  0));
    tbl.push_back(mk("lu_lw6",        1, 1, 0, 1, 0, 6, 1, 1, 0, O_DEF,   0));
    tbl.push_back(mk("lu_stall",      1, 6, 2, 1, 1, 7, 1, 0, 0, O_STALL, 0));
    tbl.push_back(mk("lu_held",       1, 6, 2, 1, 1, 7, 1, 0, 0, O_DEF,   1));
    tbl.push_back(nop("lu_fwd_wb",    0, O_FA01, 1));
    tbl.push_back(nop("lu_drain",     0, O_DEF,  1));
    tbl.push_back(mk("dh_add8a",      1, 1, 2, 1, 1, 8, 1, 0, 0, O_DEF,   1));
    tbl.push_back(mk("dh_add8b",      1, 3, 4, 1, 1, 8, 1, 0, 0, O_DEF,   1));
    tbl.push_back(mk("dh_or",         1, 8, 8, 1, 1, 9, 1, 0, 0, O_DEF,   1));
    tbl.push_back(nop("dh_mem_wins",  0, O_FAB10, 1));
    tbl.push_back(mk("byp_rs8",       1, 8, 0, 1, 1, 10, 1, 0, 0, O_BYPRS, 1));
    tbl.push_back(nop("byp_drain",    0, O_DEF,  1));
    tbl.push_back(mk("z_wr0",         1, 1, 2, 1, 1, 0, 1, 0, 0, O_DEF,   1));
    tbl.push_back(mk("z_rd0",         1, 0, 0, 1, 1, 11, 1, 0, 0, O_DEF,  1));
    tbl.push_back(nop("z_no_fwd",     0, O_DEF,  1));
    tbl.push_back(mk("z_no_byp",      1, 0, 0, 1, 1, 12, 1, 0, 0, O_DEF,  1));
    tbl.push_back(mk("z_lw0",         1, 1, 0, 1, 0, 0, 1, 1, 0, O_DEF,   1));
    tbl.push_back(mk("z_no_stall",    1, 0, 0, 1, 1, 12, 1, 0, 0, O_DEF,  1));
    tbl.push_back(nop("z_drain",      0, O_DEF,  1));
    tbl.push_back(mk("fl_lw13",       1, 1, 0, 1, 0, 13, 1, 1, 0, O_DEF,  1));
    tbl.push_back(mk("fl_over_lu",    1, 13, 13, 1, 1, 14, 1, 0, 1, O_FLUSH, 1));
    tbl.push_back(nop("fl_not_counted", 0, O_DEF, 1));
    tbl.push_back(nop("fl_alone",     1, O_FLUSH, 1));
    tbl.push_back(nop("fl_drain",     0, O_DEF,  1));

    // ---- reset state (asynchronous reset held low, ID idle)
    #2;
    drive(nop("reset_state", 0, O_DEF, 0));
    @(negedge clk);
    check_next();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // ---- saturation: five load-use stalls on a 2-bit counter
    k = 1;
    for (int it = 0; it < 5; it++) begin
      run(mk("sat_lw6",   1, 1, 0, 1, 0, 6, 1, 1, 0, O_DEF,   k));
      run(mk("sat_stall", 1, 6, 2, 1, 1, 7, 1, 0, 0, O_STALL, k));
      k = (k < 3) ? k + 1 : 3;
      run(mk("sat_held",  1, 6, 2, 1, 1, 7, 1, 0, 0, O_DEF,   k));
      run(nop("sat_fwd_wb", 0, O_FA01, k));
      run(nop("sat_drain",  0, O_DEF,  k));
    end

    // ---- asynchronous reset in the middle of a stall
    run(mk("rst_lw6",   1, 1, 0, 1, 0, 6, 1, 1, 0, O_DEF,   3));
    run(mk("rst_stall", 1, 6, 2, 1, 1, 7, 1, 0, 0, O_STALL, 3));
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back(mk("rst_async", 1, 6, 2, 1, 1, 7, 1, 0, 0, O_DEF, 0));
    check_next();
    @(posedge clk); #1;
    sb.push_back(mk("rst_held", 1, 6, 2, 1, 1, 7, 1, 0, 0, O_DEF, 0));
    check_next();
    @(negedge clk);
    reset_n = 1'b1;
    // Tags were cleared, so the add that was stalling now issues normally
    run(mk("rst_no_stall", 1, 6, 2, 1, 1, 7, 1, 0, 0, O_DEF, 0));
    run(nop("rst_drain", 0, O_DEF, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hazard_fwd_ctrl
`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard detection and forwarding controller for the 5-stage MIPS pipeline.
- Keeps a shadow pipeline of register tags (EX, MEM and WB stages).
- Compares the ID and EX source register addresses against older destination registers.
- Drives the forwarding mux selects, load-use stall/bubble, branch flush and register-file bypass. Also keeps a saturating stall counter.
- Sits beside the ID/EX pipeline registers and feeds the ALU operand muxes and the PC/IF-ID write enables.

Parameters:
ADDR_W, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  ADDR_W  ID source register 1
id_rt  in  ADDR_W  ID source register 2
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  ADDR_W  ID destination after RegDst mux
id_regwrite  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register update enable
ifid_flush  out  1  zero the IF/ID register
idex_bubble  out  1  load a NOP into ID/EX
fwd_a_sel  out  2  EX operand A: 00 regfile, 01 WB, 10 MEM
fwd_b_sel  out  2  EX operand B, same encoding as fwd_a_sel
id_byp_rs  out  1  WB result bypasses the regfile read of id_rs
id_byp_rt  out  1  WB result bypasses the regfile read of id_rt
stall_count  out  CNT_W  load-use stalls since reset, saturating

Behaviour:
- Shadow tag registers:
  - EX tag: {valid, rs, rt, uses_rs, uses_rt, dest, regwrite, memread}.
  - MEM tag and WB tag: {valid, dest, regwrite, memread}.
- Reset is asynchronous on reset_n low. All tag valid bits, all other tag fields, and stall_count clear to 0.
- Resulting outputs while in reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_*_sel=00, id_byp_*=0.
- Reset asserted mid-stall cancels the stall immediately. There is no pending state.
- Address match rule: the matching tag is valid, has regwrite=1, its dest is nonzero, and dest equals the source address. Register $0 never matches.
- Load-use condition (combinational):
  - EX tag is valid with memread=1 and regwrite=1 and a nonzero dest.
  - id_valid=1.
  - (id_uses_rs and dest==id_rs) or (id_uses_rt and dest==id_rt).
  - When true: pc_write=0, ifid_write=0, idex_bubble=1.
- Flush: ex_branch_taken=1 gives ifid_flush=1 and idex_bubble=1. pc_write and ifid_write are forced to 1.
- Priority: flush overrides load-use. A flush cycle is not counted as a stall.
- Tag advance on each rising edge:
  - WB tag <= MEM tag; MEM tag <= EX tag.
  - EX tag <= ID inputs (valid = id_valid), unless idex_bubble is asserted. Then EX tag valid <= 0.
- Stall length: exactly 1 cycle per load-use hazard. After the bubble the load sits in MEM and its data is forwarded from WB on the following cycle.
- fwd_a_sel (combinational from registered tags):
  - 10 if the MEM tag matches EX rs with uses_rs=1 and MEM memread=0.
  - else 01 if the WB tag matches EX rs with uses_rs=1.
  - else 00.
  - MEM has priority over WB (youngest value wins).
  - A MEM-stage load never sources the MEM forward; that case cannot occur after a correct stall.
- fwd_b_sel: same rules as fwd_a_sel using rt/uses_rt.
- id_byp_rs = WB tag matches id_rs, qualified by id_valid and id_uses_rs. id_byp_rt likewise for rt.
- stall_count increments by 1 on each edge where a load-use stall was asserted and flush was not. It saturates at 2^CNT_W-1 and never wraps.
- Pipeline latency: 0 cycles. All outputs are combinational from the current inputs and the registered tags.

Decomposition:
- Package hazard_pkg holds:
  - FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - ADDR_W default.
  - Packed typedefs ex_tag_t and late_tag_t.
- Sub-module reg_addr_match: inputs valid, regwrite, dest, src, use; output hit. It implements the match rule and is instanced 8 times:
  - 2 for load-use.
  - 4 for forwarding.
  - 2 for bypass.

Test Plan:
- Back-to-back ALU ops: add $3,$1,$2 then sub $4,$3,$5. Next cycle the sub is in EX with fwd_a_sel=10. No stall, stall_count=0.
- Load-use: lw $6,0($1) then add $7,$6,$2. One cycle of pc_write=0, ifid_write=0, idex_bubble=1. Then fwd_a_sel=01 with the add in EX. stall_count=1.
- Double hazard: add $8 then add $8 then or $9,$8,$8. fwd_a_sel=fwd_b_sel=10, MEM wins over WB.
- Register $0: a writer to $0 followed by a reader of $0. All fwd selects 00, no stall, id_byp_*=0.
- Simultaneous load-use and ex_branch_taken=1. ifid_flush=1, idex_bubble=1, pc_write=1, stall_count unchanged.
- CNT_W=2: five load-use stalls take stall_count to 3 where it holds. reset_n low mid-stall clears all tags, and pc_write=1 asynchronously.
